// File: rtl/booth_mul_ctrl.sv
// Iterative radix-4 Booth multiplier sequencer for RV64 MUL/MULH/MULHSU/MULHU/MULW.
// Takes one operation over a valid/ready handshake. It steps a 3-bit Booth window over the
// extended multiplier, one window per cycle, then holds the product until the consumer takes it.
//
// Ports:
//   clk, rst_n                 clock (rising edge), asynchronous active-low reset
//   flush                      kills an in-flight or held operation
//   mul_valid / mul_ready      request handshake (ready only while idle)
//   mulw                       32-bit op, only operand bits [31:0] are used
//   mul_signed                 [1] multiplicand signed, [0] multiplier signed
//   multiplicand, multiplier   operands A and B
//   out_valid / out_ready      result handshake
//   result_hi, result_lo       product[127:64] / product[63:0] (MULW: 0 / sext(product[31:0]))
module booth_mul_ctrl #(
  parameter int unsigned XLEN   = 64,
  parameter int unsigned ITER64 = 33,
  parameter int unsigned ITER32 = 17
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            mul_valid,
  output logic            mul_ready,
  input  logic            mulw,
  input  logic [1:0]      mul_signed,
  input  logic [XLEN-1:0] multiplicand,
  input  logic [XLEN-1:0] multiplier,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result_hi,
  output logic [XLEN-1:0] result_lo
);

  // Product bits above 2*XLEN are discarded, so the multiplicand and accumulator are kept
  // only that wide; arithmetic modulo 2^(2*XLEN) gives the same low bits.
  localparam int unsigned PW = 2 * XLEN;
  localparam int unsigned BW = XLEN + 2;
  localparam int unsigned HW = XLEN / 2;
  localparam int unsigned CW = $clog2(ITER64 + 1);

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e          state_q, state_d;
  logic [PW-1:0]   a_q, a_d;
  logic [BW:0]     b_q, b_d;      // bit 0 is y[-1]
  logic [PW-1:0]   acc_q, acc_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            mulw_q, mulw_d;

  logic [PW-1:0]   a_ext;
  logic [BW-1:0]   b_ext;
  logic [PW-1:0]   pp;
  logic            pp_zero, pp_two, pp_neg;

  // Operand extension for the accept edge
  always_comb begin
    if (mulw) begin
      a_ext = {{(PW-HW){mul_signed[1] & multiplicand[HW-1]}}, multiplicand[HW-1:0]};
      b_ext = {{(BW-HW){mul_signed[0] & multiplier[HW-1]}}, multiplier[HW-1:0]};
    end else begin
      a_ext = {{(PW-XLEN){mul_signed[1] & multiplicand[XLEN-1]}}, multiplicand};
      b_ext = {{(BW-XLEN){mul_signed[0] & multiplier[XLEN-1]}}, multiplier};
    end
  end

  // Booth window decode. a_q is pre-shifted each step, so it already carries the 2*i weight.
  always_comb begin
    pp_zero = 1'b0;
    pp_two  = 1'b0;
    pp_neg  = 1'b0;
    unique case (b_q[2:0])
      3'b000, 3'b111: pp_zero = 1'b1;
      3'b001, 3'b010: ;
      3'b011:         pp_two  = 1'b1;
      3'b100: begin
        pp_two = 1'b1;
        pp_neg = 1'b1;
      end
      3'b101, 3'b110: pp_neg  = 1'b1;
      default:        pp_zero = 1'b1;
    endcase
    if (pp_zero) begin
      pp = '0;
    end else if (pp_two) begin
      pp = {a_q[PW-2:0], 1'b0};
    end else begin
      pp = a_q;
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    mulw_d  = mulw_q;
    unique case (state_q)
      StIdle: begin
        if (mul_valid && !flush) begin
          a_d     = a_ext;
          b_d     = {b_ext, 1'b0};
          acc_d   = '0;
          cnt_d   = mulw ? CW'(ITER32) : CW'(ITER64);
          mulw_d  = mulw;
          state_d = StBusy;
        end
      end
      StBusy: begin
        if (flush) begin
          state_d = StIdle;
        end else begin
          acc_d = pp_neg ? acc_q - pp : acc_q + pp;
          a_d   = {a_q[PW-3:0], 2'b00};
          b_d   = {2'b00, b_q[BW:2]};
          cnt_d = cnt_q - 1'b1;
          if (cnt_q == CW'(1)) begin
            state_d = StDone;
          end
        end
      end
      StDone: begin
        if (flush || out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      mulw_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      mulw_q  <= mulw_d;
    end
  end

  always_comb begin
    mul_ready = (state_q == StIdle);
    out_valid = (state_q == StDone);
    if (mulw_q) begin
      result_hi = '0;
      result_lo = {{(XLEN-HW){acc_q[HW-1]}}, acc_q[HW-1:0]};
    end else begin
      result_hi = acc_q[PW-1:XLEN];
      result_lo = acc_q[XLEN-1:0];
    end
  end

endmodule

// File: tb/tb_booth_mul_ctrl.sv
module tb_booth_mul_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        flush = 1'b0;
  logic        mul_valid = 1'b0;
  logic        mul_ready;
  logic        mulw = 1'b0;
  logic [1:0]  mul_signed = 2'b00;
  logic [63:0] multiplicand = '0;
  logic [63:0] multiplier = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [63:0] result_hi;
  logic [63:0] result_lo;

  booth_mul_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush        (flush),
    .mul_valid    (mul_valid),
    .mul_ready    (mul_ready),
    .mulw         (mulw),
    .mul_signed   (mul_signed),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .result_hi    (result_hi),
    .result_lo    (result_lo)
  );

  always #5 clk = ~clk;

  int nvec = 0;
  int nfail = 0;
  logic        armed = 1'b0;   // a result is legitimately expected
  logic [63:0] exp_hi = '0;
  logic [63:0] exp_lo = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Reference: full-width arithmetic product of the extended operands.
  function automatic logic [127:0] model(input logic [63:0] a, input logic [63:0] b,
                                         input logic [1:0] sg, input logic w);
    logic [127:0] ae, be, p;
    if (w) begin
      ae = sg[1] ? {{96{a[31]}}, a[31:0]} : {96'b0, a[31:0]};
      be = sg[0] ? {{96{b[31]}}, b[31:0]} : {96'b0, b[31:0]};
      p  = ae * be;
      return {64'b0, {32{p[31]}}, p[31:0]};
    end
    ae = sg[1] ? {{64{a[63]}}, a} : {64'b0, a};
    be = sg[0] ? {{64{b[63]}}, b} : {64'b0, b};
    return ae * be;
  endfunction

  // Compare process: whenever a result is presented it must be expected and correct.
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      chk("out_valid_expected", {63'b0, armed}, 64'd1);
      if (armed) begin
        chk("result_hi", result_hi, exp_hi);
        chk("result_lo", result_lo, exp_lo);
      end
      chk("mul_ready_in_done", {63'b0, mul_ready}, 64'd0);
    end
  end

  task automatic accept(input logic [63:0] a, input logic [63:0] b, input logic [1:0] sg,
                        input logic w, input logic early);
    @(negedge clk);
    mul_valid = 1'b1;
    multiplicand = a;
    multiplier = b;
    mul_signed = sg;
    mulw = w;
    out_ready = early;
    chk("ready_before_accept", {63'b0, mul_ready}, 64'd1);
    @(posedge clk);
    #1;
    // Operands are scrambled after accept; they must have no effect.
    mul_valid = 1'b0;
    multiplicand = {$urandom, $urandom};
    multiplier = {$urandom, $urandom};
    mul_signed = 2'($urandom_range(0, 3));
    mulw = 1'($urandom_range(0, 1));
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic run_op(input logic [63:0] a, input logic [63:0] b, input logic [1:0] sg,
                        input logic w, input int hold, input logic early);
    int lat;
    {exp_hi, exp_lo} = model(a, b, sg, w);
    armed = 1'b1;
    accept(a, b, sg, w, early);
    wait_valid(lat);
    chk("latency", 64'(lat), w ? 64'd17 : 64'd33);
    if (!early) begin
      repeat (hold) begin
        @(posedge clk);
        #1;
        chk("held_valid", {63'b0, out_valid}, 64'd1);
      end
      out_ready = 1'b1;
    end
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    armed = 1'b0;
    chk("valid_after_handshake", {63'b0, out_valid}, 64'd0);
    chk("ready_after_handshake", {63'b0, mul_ready}, 64'd1);
  endtask

  initial begin
    logic [127:0] m;
    int lat;

    // Model pins against hand-computed values
    m = model(64'd3, 64'd5, 2'b00, 1'b0);
    chk("model_3x5_lo", m[63:0], 64'd15);
    m = model('1, '1, 2'b00, 1'b0);
    chk("model_uu_hi", m[127:64], 64'hFFFF_FFFF_FFFF_FFFE);
    m = model('1, '1, 2'b10, 1'b0);
    chk("model_su_hi", m[127:64], 64'hFFFF_FFFF_FFFF_FFFF);
    m = model(64'h7FFF_FFFF, 64'd2, 2'b00, 1'b1);
    chk("model_w_lo", m[63:0], 64'hFFFF_FFFF_FFFF_FFFE);

    // Reset values
    #1 rst_n = 1'b0;
    #1;
    chk("rst_ready", {63'b0, mul_ready}, 64'd1);
    chk("rst_valid", {63'b0, out_valid}, 64'd0);
    chk("rst_hi", result_hi, 64'd0);
    chk("rst_lo", result_lo, 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // 1: unsigned 3x5, out_ready high throughout
    run_op(64'd3, 64'd5, 2'b00, 1'b0, 0, 1'b1);
    // 2: -1 x -1 signed and unsigned
    run_op('1, '1, 2'b11, 1'b0, 0, 1'b1);
    chk("t2_exp_lo", exp_lo, 64'd1);
    run_op('1, '1, 2'b00, 1'b0, 2, 1'b0);
    // 3: MULHSU
    run_op('1, '1, 2'b10, 1'b0, 1, 1'b0);
    // 4: MULW
    run_op(64'h7FFF_FFFF, 64'd2, 2'b00, 1'b1, 0, 1'b1);
    // 5: backpressure for 10 cycles
    run_op(64'h1234_5678_9ABC_DEF0, 64'hFEDC_BA98_7654_3210, 2'b11, 1'b0, 10, 1'b0);

    // 5: flush at BUSY cycle 5
    accept(64'd11, 64'd13, 2'b00, 1'b0, 1'b0);
    repeat (4) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    chk("flush_busy_ready", {63'b0, mul_ready}, 64'd1);
    chk("flush_busy_valid", {63'b0, out_valid}, 64'd0);
    repeat (40) @(posedge clk);
    run_op(64'd7, 64'd9, 2'b00, 1'b0, 0, 1'b1);
    chk("t5_exp_lo", exp_lo, 64'd63);

    // Flush in DONE discards the result even with out_ready low
    {exp_hi, exp_lo} = model(64'd100, 64'd200, 2'b01, 1'b0);
    armed = 1'b1;
    accept(64'd100, 64'd200, 2'b01, 1'b0, 1'b0);
    wait_valid(lat);
    chk("flush_done_latency", 64'(lat), 64'd33);
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    armed = 1'b0;
    chk("flush_done_valid", {63'b0, out_valid}, 64'd0);
    chk("flush_done_ready", {63'b0, mul_ready}, 64'd1);

    // Flush beats a request in IDLE
    @(negedge clk);
    mul_valid = 1'b1;
    flush = 1'b1;
    @(posedge clk);
    #1;
    mul_valid = 1'b0;
    flush = 1'b0;
    chk("flush_idle_ready", {63'b0, mul_ready}, 64'd1);
    repeat (40) @(posedge clk);

    // 6: async reset at BUSY cycle 12
    accept(64'hDEAD_BEEF_0BAD_F00D, 64'h0123_4567_89AB_CDEF, 2'b11, 1'b0, 1'b0);
    repeat (11) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_ready", {63'b0, mul_ready}, 64'd1);
    chk("arst_valid", {63'b0, out_valid}, 64'd0);
    chk("arst_hi", result_hi, 64'd0);
    chk("arst_lo", result_lo, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(posedge clk);
    #1 chk("arst_ready_after", {63'b0, mul_ready}, 64'd1);

    // Random mix
    for (int i = 0; i < 12; i++) begin
      logic [63:0] ra, rb;
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      if (i == 0) ra = 64'h8000_0000_0000_0000;
      if (i == 1) rb = 64'h8000_0000_8000_0000;
      run_op(ra, rb, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
             $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end

    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
